// File: rtl/sfx_player_if.sv
// Control/sample bundle between the ball logic, the sound-effect player and the DAC pins.
// master: event/enable source and sample consumer; slave: the player.
interface sfx_player_if;
  logic       enable;
  logic       play_sound1;
  logic       play_sound2;
  logic [3:0] tono;
  logic       busy;
  logic [1:0] note;

  modport master (
    output enable, play_sound1, play_sound2,
    input  tono, busy, note
  );

  modport slave (
    input  enable, play_sound1, play_sound2,
    output tono, busy, note
  );
endinterface

// File: rtl/sfx_player.sv
// Sound-effect sequencer: paddle hit plays DO, brick hit plays MI then SOL, as 4-bit sine samples.
// Optional macro SFX_FADE_EN: halve the amplitude around midscale for the second half of each note.
module sfx_player #(
  parameter int unsigned DIV_DO  = 2986,
  parameter int unsigned DIV_MI  = 2369,
  parameter int unsigned DIV_SOL = 1993,
  parameter int unsigned DUR     = 2500000
) (
  input logic         clk,
  input logic         reset_button,
  sfx_player_if.slave sfx
);

  localparam int unsigned DIV_MAX =
    (DIV_DO > DIV_MI) ? ((DIV_DO > DIV_SOL) ? DIV_DO : DIV_SOL)
                      : ((DIV_MI > DIV_SOL) ? DIV_MI : DIV_SOL);
  localparam int unsigned SW = $clog2(DIV_MAX);
  localparam int unsigned DW = $clog2(DUR);

  // round(7.5 + 7.5*sin(2*pi*k/32))
  localparam logic [3:0] SINE [32] = '{
    4'd8,  4'd9,  4'd10, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15,
    4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd10, 4'd9,
    4'd8,  4'd6,  4'd5,  4'd3,  4'd2,  4'd1,  4'd1,  4'd0,
    4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd3,  4'd5,  4'd6
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S1_DO  = 2'd1,
    S2_MI  = 2'd2,
    S2_SOL = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          enter;
  logic [2:0]    s1_sync, s2_sync;
  logic          trig1, trig2;
  logic [DW-1:0] dur_cnt;
  logic [SW-1:0] step_cnt, step_max;
  logic [4:0]    addr;
  logic          dur_last, step_last;
  logic [3:0]    raw, sample;

  always_comb begin
    step_max = '0;
    case (state)
      S1_DO:   step_max = SW'(DIV_DO - 1);
      S2_MI:   step_max = SW'(DIV_MI - 1);
      S2_SOL:  step_max = SW'(DIV_SOL - 1);
      default: step_max = '0;
    endcase
  end

  assign dur_last  = (dur_cnt == DW'(DUR - 1));
  assign step_last = (step_cnt == step_max);

  // trig2 outranks trig1; trig1 only (re)starts sfx1 when sfx2 is not playing
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    if (!sfx.enable) begin
      state_nxt = IDLE;
    end else if (trig2) begin
      state_nxt = S2_MI;
      enter     = 1'b1;
    end else if (trig1 && (state == IDLE || state == S1_DO)) begin
      state_nxt = S1_DO;
      enter     = 1'b1;
    end else if (dur_last) begin
      case (state)
        S1_DO:   state_nxt = IDLE;
        S2_MI: begin
          state_nxt = S2_SOL;
          enter     = 1'b1;
        end
        S2_SOL:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    raw = SINE[addr];
`ifdef SFX_FADE_EN
    sample = (dur_cnt >= DW'(DUR / 2)) ? (4'd4 + {1'b0, raw[3:1]}) : raw;
`else
    sample = raw;
`endif
  end

  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      s1_sync  <= '0;
      s2_sync  <= '0;
      trig1    <= 1'b0;
      trig2    <= 1'b0;
      state    <= IDLE;
      sfx.busy <= 1'b0;
      sfx.note <= 2'd0;
      sfx.tono <= 4'd8;
      dur_cnt  <= '0;
      step_cnt <= '0;
      addr     <= '0;
    end else begin
      s1_sync <= {s1_sync[1:0], sfx.play_sound1};
      s2_sync <= {s2_sync[1:0], sfx.play_sound2};
      trig1   <= s1_sync[1] & ~s1_sync[2];
      trig2   <= s2_sync[1] & ~s2_sync[2];

      state    <= state_nxt;
      sfx.busy <= (state_nxt != IDLE);
      sfx.note <= state_nxt;

      if (enter || state_nxt == IDLE) begin
        dur_cnt  <= '0;
        step_cnt <= '0;
        addr     <= '0;
      end else begin
        dur_cnt <= dur_cnt + 1'b1;
        if (step_last) begin
          step_cnt <= '0;
          addr     <= addr + 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end

      // sample lags the address by one cycle; mute forces midscale immediately
      if (!sfx.enable || state == IDLE)
        sfx.tono <= 4'd8;
      else
        sfx.tono <= sample;
    end
  end

endmodule
